// File: rtl/writeback_unit.sv
// Final pipeline stage: accepts retiring instructions, extracts load data and drives the register-bank write port.
// Optional same-cycle forwarding to decode is enabled by defining WRITEBACK_BYPASS_EN.
module writeback_unit #(
  parameter int LOAD_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_rd,
  input  logic        in_is_load,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] in_alu_result,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        reg_wr_en,
  output logic [4:0]  reg_wr_addr,
  output logic [31:0] reg_wr_data,
  output logic        fwd_valid,
  output logic [4:0]  fwd_addr,
  output logic [31:0] fwd_data,
  output logic        err_misaligned,
  output logic        err_timeout,
  output logic [31:0] retired_count
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_LOAD = 2'd1,
    WRITE     = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT_C = 8'(LOAD_TIMEOUT);

  state_t      state_r, nxt_state_s;
  logic [4:0]  rd_r;
  logic [2:0]  funct3_r;
  logic [1:0]  off_r;
  logic [7:0]  tcnt_r, nxt_tcnt_s;
  logic        wr_en_r, err_mis_r, err_to_r;
  logic [4:0]  wr_addr_r;
  logic [31:0] wr_data_r, count_r;
  logic        accept_s, write_s, nxt_wr_en_s, nxt_err_mis_s, nxt_err_to_s;
  logic [4:0]  nxt_wr_addr_s;
  logic [31:0] nxt_wr_data_s;

  // Byte/halfword extraction with sign or zero extension; unsupported codes act as LW.
  function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[8*off +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  load_extract = {{24{b[7]}}, b};
      3'b100:  load_extract = {24'd0, b};
      3'b001:  load_extract = {{16{h[15]}}, h};
      3'b101:  load_extract = {16'd0, h};
      default: load_extract = word;
    endcase
  endfunction

  function automatic logic load_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      3'b000, 3'b100: load_misaligned = 1'b0;
      3'b001, 3'b101: load_misaligned = off[0];
      default:        load_misaligned = (off != 2'd0);
    endcase
  endfunction

  assign in_ready = (state_r != WAIT_LOAD);
  assign accept_s = in_valid && in_ready;

  // Next-state and next-output computation.
  always_comb begin
    nxt_state_s   = state_r;
    nxt_tcnt_s    = tcnt_r;
    write_s       = 1'b0;
    nxt_wr_addr_s = wr_addr_r;
    nxt_wr_data_s = wr_data_r;
    nxt_err_mis_s = 1'b0;
    nxt_err_to_s  = 1'b0;
    case (state_r)
      IDLE, WRITE: begin
        if (accept_s && in_is_load) begin
          nxt_state_s = WAIT_LOAD;
          nxt_tcnt_s  = 8'd0;
        end else if (accept_s) begin
          nxt_state_s   = WRITE;
          write_s       = 1'b1;
          nxt_wr_addr_s = in_rd;
          nxt_wr_data_s = in_alu_result;
        end else begin
          nxt_state_s = IDLE;
        end
      end
      WAIT_LOAD: begin
        // rvalid wins over a timeout expiring in the same cycle
        if (dmem_rvalid && load_misaligned(funct3_r, off_r)) begin
          nxt_state_s   = IDLE;
          nxt_err_mis_s = 1'b1;
        end else if (dmem_rvalid) begin
          nxt_state_s   = WRITE;
          write_s       = 1'b1;
          nxt_wr_addr_s = rd_r;
          nxt_wr_data_s = load_extract(funct3_r, off_r, dmem_rdata);
        end else if ((tcnt_r + 8'd1) >= TIMEOUT_C) begin
          nxt_state_s  = IDLE;
          nxt_err_to_s = 1'b1;
        end else begin
          nxt_tcnt_s = tcnt_r + 8'd1;
        end
      end
      default: begin
        nxt_state_s = IDLE;
      end
    endcase
    nxt_wr_en_s = write_s && (nxt_wr_addr_s != 5'd0);
  end

  // State, holding registers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      rd_r      <= 5'd0;
      funct3_r  <= 3'd0;
      off_r     <= 2'd0;
      tcnt_r    <= 8'd0;
      wr_en_r   <= 1'b0;
      wr_addr_r <= 5'd0;
      wr_data_r <= 32'd0;
      err_mis_r <= 1'b0;
      err_to_r  <= 1'b0;
      count_r   <= 32'd0;
    end else begin
      state_r   <= nxt_state_s;
      tcnt_r    <= nxt_tcnt_s;
      wr_en_r   <= nxt_wr_en_s;
      wr_addr_r <= nxt_wr_addr_s;
      wr_data_r <= nxt_wr_data_s;
      err_mis_r <= nxt_err_mis_s;
      err_to_r  <= nxt_err_to_s;
      if (accept_s) begin
        rd_r     <= in_rd;
        funct3_r <= in_funct3;
        off_r    <= in_alu_result[1:0];
      end
      if (write_s) begin
        count_r <= count_r + 32'd1;
      end
    end
  end

  assign reg_wr_en      = wr_en_r;
  assign reg_wr_addr    = wr_addr_r;
  assign reg_wr_data    = wr_data_r;
  assign err_misaligned = err_mis_r;
  assign err_timeout    = err_to_r;
  assign retired_count  = count_r;

`ifdef WRITEBACK_BYPASS_EN
  assign fwd_valid = nxt_wr_en_s && !rst;
  assign fwd_addr  = (nxt_wr_en_s && !rst) ? nxt_wr_addr_s : 5'd0;
  assign fwd_data  = (nxt_wr_en_s && !rst) ? nxt_wr_data_s : 32'd0;
`else
  assign fwd_valid = 1'b0;
  assign fwd_addr  = 5'd0;
  assign fwd_data  = 32'd0;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Directed self-checking bench for writeback_unit.
module tb_writeback_unit;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, in_is_load, dmem_rvalid;
  logic [4:0]  in_rd;
  logic [2:0]  in_funct3;
  logic [31:0] in_alu_result, dmem_rdata;
  logic        reg_wr_en, fwd_valid, err_misaligned, err_timeout;
  logic [4:0]  reg_wr_addr, fwd_addr;
  logic [31:0] reg_wr_data, fwd_data, retired_count;
  int n_cmp = 0;
  int n_err = 0;

  writeback_unit #(.LOAD_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd),
    .in_is_load(in_is_load), .in_funct3(in_funct3), .in_alu_result(in_alu_result),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .reg_wr_en(reg_wr_en),
    .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data), .fwd_valid(fwd_valid),
    .fwd_addr(fwd_addr), .fwd_data(fwd_data), .err_misaligned(err_misaligned),
    .err_timeout(err_timeout), .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept a load, wait 'gap' cycles, then deliver rdata with rvalid.
  task automatic do_load(input logic [4:0] rd, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] rdata, input int gap);
    in_valid = 1'b1; in_is_load = 1'b1; in_rd = rd; in_funct3 = f3; in_alu_result = addr;
    step();
    in_valid = 1'b0; in_is_load = 1'b0;
    chk("load_wait_ready", {31'd0, in_ready}, 32'd0);
    repeat (gap) step();
    dmem_rvalid = 1'b1; dmem_rdata = rdata;
    step();
    dmem_rvalid = 1'b0;
  endtask

  task automatic chk_write(input string tag, input logic [4:0] addr, input logic [31:0] data,
                           input logic [31:0] cnt);
    chk({tag, "_en"}, {31'd0, reg_wr_en}, 32'd1);
    chk({tag, "_addr"}, {27'd0, reg_wr_addr}, {27'd0, addr});
    chk({tag, "_data"}, reg_wr_data, data);
    chk({tag, "_cnt"}, retired_count, cnt);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_rd = 5'd0; in_is_load = 1'b0; in_funct3 = 3'd0;
    in_alu_result = 32'd0; dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
    #12;
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_wr_en", {31'd0, reg_wr_en}, 32'd0);
    chk("rst_addr", {27'd0, reg_wr_addr}, 32'd0);
    chk("rst_data", reg_wr_data, 32'd0);
    chk("rst_cnt", retired_count, 32'd0);
    chk("rst_err", {30'd0, err_misaligned, err_timeout}, 32'd0);
    chk("rst_fwd", {26'd0, fwd_valid, fwd_addr} | fwd_data, 32'd0);
    rst = 1'b0;
    step();

    // Single ALU op
    in_valid = 1'b1; in_rd = 5'd5; in_alu_result = 32'hDEADBEEF;
    step();
    in_valid = 1'b0;
    chk_write("alu1", 5'd5, 32'hDEADBEEF, 32'd1);
    step();
    chk("alu1_once", {31'd0, reg_wr_en}, 32'd0);

    // Forwarding seen combinationally before the edge that sets reg_wr_en
    in_valid = 1'b1; in_rd = 5'd4; in_alu_result = 32'h11111111;
    #1;
    chk("fwd_pre_wr_en", {31'd0, reg_wr_en}, 32'd0);
`ifdef WRITEBACK_BYPASS_EN
    chk("fwd_valid", {31'd0, fwd_valid}, 32'd1);
    chk("fwd_addr", {27'd0, fwd_addr}, 32'd4);
    chk("fwd_data", fwd_data, 32'h11111111);
`else
    chk("fwd_off", {26'd0, fwd_valid, fwd_addr} | fwd_data, 32'd0);
`endif
    step();
    in_valid = 1'b0;
    chk_write("alu2", 5'd4, 32'h11111111, 32'd2);
    step();

    // Loads with extraction
    do_load(5'd7, 3'b000, 32'h0000_1002, 32'h0080_0000, 1);
    chk_write("lb", 5'd7, 32'hFFFFFF80, 32'd3);
    step();
    do_load(5'd7, 3'b100, 32'h0000_1002, 32'h0080_0000, 0);
    chk_write("lbu", 5'd7, 32'h00000080, 32'd4);
    step();
    do_load(5'd8, 3'b101, 32'h0000_2002, 32'h8001_0000, 3);
    chk_write("lhu", 5'd8, 32'h00008001, 32'd5);
    step();
    do_load(5'd9, 3'b001, 32'h0000_2000, 32'h1234_F00D, 0);
    chk_write("lh", 5'd9, 32'hFFFFF00D, 32'd6);
    step();
    do_load(5'd3, 3'b010, 32'h0000_3000, 32'hCAFEBABE, 2);
    chk_write("lw", 5'd3, 32'hCAFEBABE, 32'd7);
    step();

    // Back-to-back ALU ops, rd=0 suppresses the strobe but still counts
    in_valid = 1'b1; in_rd = 5'd1; in_alu_result = 32'h0000_0001;
    step();
    chk_write("b2b1", 5'd1, 32'h0000_0001, 32'd8);
    in_rd = 5'd2; in_alu_result = 32'h0000_0002;
    step();
    chk_write("b2b2", 5'd2, 32'h0000_0002, 32'd9);
    in_rd = 5'd0; in_alu_result = 32'h0000_0003;
    step();
    in_valid = 1'b0;
    chk("b2b_x0_en", {31'd0, reg_wr_en}, 32'd0);
    chk("b2b_x0_cnt", retired_count, 32'd10);
    step();
    chk("b2b_idle_en", {31'd0, reg_wr_en}, 32'd0);

    // Misaligned LW
    do_load(5'd9, 3'b010, 32'h0000_4001, 32'h5555_AAAA, 2);
    chk("mis_pulse", {31'd0, err_misaligned}, 32'd1);
    chk("mis_no_wr", {31'd0, reg_wr_en}, 32'd0);
    chk("mis_cnt", retired_count, 32'd10);
    chk("mis_ready", {31'd0, in_ready}, 32'd1);
    step();
    chk("mis_one_cycle", {31'd0, err_misaligned}, 32'd0);

    // Timeout: 15 cycles in WAIT_LOAD without rvalid
    in_valid = 1'b1; in_is_load = 1'b1; in_rd = 5'd9; in_funct3 = 3'b010; in_alu_result = 32'h0;
    step();
    in_valid = 1'b0; in_is_load = 1'b0;
    repeat (14) step();
    chk("to_not_yet", {30'd0, err_timeout, in_ready}, 32'd0);
    step();
    chk("to_pulse", {31'd0, err_timeout}, 32'd1);
    chk("to_ready", {31'd0, in_ready}, 32'd1);
    chk("to_no_wr", {31'd0, reg_wr_en}, 32'd0);
    chk("to_cnt", retired_count, 32'd10);
    step();
    chk("to_one_cycle", {31'd0, err_timeout}, 32'd0);

    // rvalid outside WAIT_LOAD is ignored
    dmem_rvalid = 1'b1; dmem_rdata = 32'h1234_5678;
    step();
    dmem_rvalid = 1'b0;
    chk("stray_rvalid", {31'd0, reg_wr_en}, 32'd0);

    // Reset mid-load abandons it
    in_valid = 1'b1; in_is_load = 1'b1; in_rd = 5'd12; in_funct3 = 3'b010; in_alu_result = 32'h0;
    step();
    in_valid = 1'b0; in_is_load = 1'b0;
    step();
    rst = 1'b1;
    #2;
    chk("rst_mid_outs", {25'd0, reg_wr_en, err_misaligned, err_timeout, reg_wr_addr} | reg_wr_data, 32'd0);
    chk("rst_mid_cnt", retired_count, 32'd0);
    chk("rst_mid_ready", {31'd0, in_ready}, 32'd1);
    rst = 1'b0;
    dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    step();
    dmem_rvalid = 1'b0;
    chk("rst_mid_no_wr", {31'd0, reg_wr_en}, 32'd0);
    chk("rst_mid_cnt2", retired_count, 32'd0);
    chk("rst_mid_data", reg_wr_data, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
